// File: rtl/dot_product_sequencer_if.sv
// ---------------------------------------------------------------------------
// dot_product_sequencer_if : input, weight, dot-unit and result buses (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface dot_product_sequencer_if #(
  parameter int W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_data [0:7];

  logic [2:0]          w_addr;
  logic signed [W-1:0] w_data [0:7];

  logic                dp_rst;
  logic signed [W-1:0] dp_a [0:7];
  logic signed [W-1:0] dp_b [0:7];
  logic signed [W-1:0] dp_out;
  logic                dp_valid;

  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_data;
  logic [2:0]          out_idx;
  logic                out_last;

  modport master (
    input  in_valid, in_data, w_data, dp_out, dp_valid, out_ready,
    output in_ready, w_addr, dp_rst, dp_a, dp_b, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    output in_valid, in_data, w_data, dp_out, dp_valid, out_ready,
    input  in_ready, w_addr, dp_rst, dp_a, dp_b, out_valid, out_data, out_idx, out_last
  );
endinterface

`default_nettype wire

// File: rtl/dot_product_sequencer.sv
// ---------------------------------------------------------------------------
// dot_product_sequencer : runs one input vector against K weight rows (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module dot_product_sequencer #(
  parameter int W       = 16,
  parameter int K       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  dot_product_sequencer_if.master bus,
  output logic                    busy,
  output logic                    err
);

  localparam int              WD_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);
  localparam logic [2:0]      LAST_ROW = 3'(K - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_EMIT  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          row_q, row_d;
  logic [2:0]          w_addr_q, w_addr_d;
  logic signed [W-1:0] x_q [0:7];
  logic signed [W-1:0] x_d [0:7];
  logic signed [W-1:0] w_q [0:7];
  logic signed [W-1:0] w_d [0:7];
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                dp_rst_q, dp_rst_d;
  logic signed [W-1:0] out_data_q, out_data_d;
  logic [2:0]          out_idx_q, out_idx_d;
  logic                out_last_q, out_last_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      w_addr_q   <= '0;
      x_q        <= '{default: '0};
      w_q        <= '{default: '0};
      wd_q       <= '0;
      dp_rst_q   <= 1'b1;
      out_data_q <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      w_addr_q   <= w_addr_d;
      x_q        <= x_d;
      w_q        <= w_d;
      wd_q       <= wd_d;
      dp_rst_q   <= dp_rst_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      out_last_q <= out_last_d;
      err_q      <= err_d;
    end
  end

  // dp_rst is registered, so it is high exactly during LOAD and RUN never
  // sees the dot unit's previous-row valid.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    w_addr_d   = w_addr_q;
    x_d        = x_q;
    w_d        = w_q;
    wd_d       = wd_q;
    dp_rst_d   = 1'b0;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    out_last_d = out_last_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          x_d      = bus.in_data;
          row_d    = 3'd0;
          w_addr_d = 3'd0;
          err_d    = 1'b0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        w_d      = bus.w_data;
        dp_rst_d = 1'b1;
        state_d  = S_LOAD;
      end
      S_LOAD: begin
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.dp_valid) begin
          out_data_d = bus.dp_out;
          out_idx_d  = row_q;
          out_last_d = (row_q == LAST_ROW);
          state_d    = S_EMIT;
        end else if (wd_q == WD_LIMIT) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          if (row_q == LAST_ROW) begin
            state_d = S_IDLE;
          end else begin
            row_d    = row_q + 3'd1;
            w_addr_d = row_q + 3'd1;
            state_d  = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.w_addr    = w_addr_q;
  assign bus.dp_rst    = dp_rst_q;
  assign bus.dp_a      = x_q;
  assign bus.dp_b      = w_q;
  assign bus.out_valid = (state_q == S_EMIT);
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state_q != S_IDLE);
  assign err           = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dot_product_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dot_product_sequencer : table vectors, scoreboard and corner sequences (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dot_product_sequencer;
  localparam int W       = 16;
  localparam int K       = 4;
  localparam int TIMEOUT = 15;
  localparam int DP_LAT  = 7;
  localparam int NVEC    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, err;

  always #5 clk = ~clk;

  dot_product_sequencer_if #(.W(W)) bus ();

  dot_product_sequencer #(.W(W), .K(K), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.master),
    .busy (busy),
    .err  (err)
  );

  typedef struct packed {
    logic [15:0]      x;
    logic [3:0][15:0] w;
    logic [3:0][15:0] e;
  } vec_t;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  vec_t              tbl [0:NVEC-1];
  exp_t              sbq [$];
  logic signed [15:0] mem [0:7][0:7];
  int                n_checks = 0;
  int                n_pass   = 0;
  logic              dp_en;
  logic              dp_run;
  int                dp_cnt;

  task automatic chk(input string nm, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
  endtask

  function automatic logic signed [15:0] dot(input logic signed [15:0] a [0:7],
                                             input logic signed [15:0] b [0:7]);
    longint s = 0;
    for (int i = 0; i < 8; i++) s += longint'(a[i]) * longint'(b[i]);
    return 16'(s >>> 12);
  endfunction

  // Weight memory: data for the registered w_addr is visible the cycle after issue.
  always_comb begin
    for (int c = 0; c < 8; c++) bus.w_data[c] = mem[bus.w_addr][c];
  end

  // Dot unit: cleared by dp_rst, result DP_LAT cycles later, valid held until next dp_rst.
  always @(posedge clk) begin
    if (bus.dp_rst) begin
      dp_cnt       <= 1;
      dp_run       <= 1'b1;
      bus.dp_valid <= 1'b0;
    end else if (dp_run && dp_en) begin
      if (dp_cnt == DP_LAT - 1) begin
        bus.dp_valid <= 1'b1;
        bus.dp_out   <= dot(bus.dp_a, bus.dp_b);
        dp_run       <= 1'b0;
      end else begin
        dp_cnt <= dp_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_nonempty", 0, 1);
      end else begin
        e = sbq.pop_front();
        chk("out_data", int'($unsigned(bus.out_data)), int'(e.data));
        chk("out_idx", int'(bus.out_idx), int'(e.idx));
        chk("out_last", int'(bus.out_last), int'(e.last));
      end
    end
  end

  task automatic set_vec(input int i, input logic [15:0] x,
                         input logic [15:0] w0, w1, w2, w3,
                         input logic [15:0] e0, e1, e2, e3);
    tbl[i].x    = x;
    tbl[i].w[0] = w0; tbl[i].w[1] = w1; tbl[i].w[2] = w2; tbl[i].w[3] = w3;
    tbl[i].e[0] = e0; tbl[i].e[1] = e1; tbl[i].e[2] = e2; tbl[i].e[3] = e3;
  endtask

  // Call at posedge+#1 with the DUT idle; returns #1 after the accepting edge.
  task automatic send_vec(input int vi, input bit push);
    exp_t item;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < 8; c++) mem[r][c] = tbl[vi].w[r];
    for (int c = 0; c < 8; c++) bus.in_data[c] = tbl[vi].x;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (push) begin
      for (int r = 0; r < K; r++) begin
        item.data = tbl[vi].e[r];
        item.idx  = 3'(r);
        item.last = (r == K - 1);
        sbq.push_back(item);
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && sbq.size() == 0) break;
    end
    chk("drain_busy", int'(busy), 0);
    chk("drain_sb_empty", sbq.size(), 0);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    chk("wait_out_valid", int'(bus.out_valid), 1);
  endtask

  task automatic wait_load();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.dp_rst) break;
    end
    chk("reach_load", int'(bus.dp_rst), 1);
  endtask

  task automatic pulse_ready();
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.out_ready = 1'b0;
  endtask

  initial begin
    int  n;
    bit  saw;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    dp_en         = 1'b1;
    for (int c = 0; c < 8; c++) bus.in_data[c] = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mem[r][c] = '0;

    set_vec(0, 16'h0200, 16'h1000, 16'h0800, 16'hF000, 16'h0400,
                         16'h1000, 16'h0800, 16'hF000, 16'h0400);
    set_vec(1, 16'hFF00, 16'h1000, 16'h0800, 16'hE000, 16'h0010,
                         16'hF800, 16'hFC00, 16'h1000, 16'hFFF8);
    set_vec(2, 16'h0080, 16'h7FFF, 16'h8000, 16'h0001, 16'h1234,
                         16'h1FFF, 16'hE000, 16'h0000, 16'h048D);

    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_dp_rst", int'(bus.dp_rst), 1);
    chk("rst_w_addr", int'(bus.w_addr), 0);
    chk("rst_out_data", int'($unsigned(bus.out_data)), 0);
    chk("rst_out_idx", int'(bus.out_idx), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("dp_rst_until_edge", int'(bus.dp_rst), 1);
    @(negedge clk);
    chk("dp_rst_dropped", int'(bus.dp_rst), 0);

    // Table vectors with an always-ready sink: 4 rows x 10 cycles each.
    for (int vi = 0; vi < NVEC; vi++) begin
      @(posedge clk); #1;
      send_vec(vi, 1'b1);
      n = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (!busy) break;
        n++;
      end
      chk("vector_cycles", n, 10 * K);
      chk("vector_sb_empty", sbq.size(), 0);
    end

    // Backpressure: row 1 held for 5 cycles with out_ready low.
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    send_vec(0, 1'b1);
    for (int r = 0; r < K; r++) begin
      wait_valid();
      chk("bp_idx", int'(bus.out_idx), r);
      if (r == 1) begin
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("bp_valid_held", int'(bus.out_valid), 1);
          chk("bp_data_held", int'($unsigned(bus.out_data)), int'(tbl[0].e[1]));
          chk("bp_idx_held", int'(bus.out_idx), 1);
          chk("bp_no_fetch", int'(bus.w_addr), 1);
        end
      end
      pulse_ready();
    end
    bus.out_ready = 1'b1;
    wait_idle();

    // in_valid with different data during RUN must be ignored.
    @(posedge clk); #1;
    send_vec(1, 1'b1);
    wait_load();
    @(posedge clk); #1;
    for (int c = 0; c < 8; c++) bus.in_data[c] = tbl[2].x;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("run_in_ready", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    wait_idle();

    // Watchdog abort with a dead dot unit, then recovery clears err.
    dp_en = 1'b0;
    @(posedge clk); #1;
    send_vec(0, 1'b0);
    wait_load();
    n   = 0;
    saw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) saw = 1'b1;
      if (err) break;
      n++;
    end
    chk("timeout_cycles", n, TIMEOUT);
    chk("timeout_err", int'(err), 1);
    chk("timeout_idle", int'(busy), 0);
    chk("timeout_in_ready", int'(bus.in_ready), 1);
    chk("timeout_no_output", int'(saw), 0);
    repeat (3) @(negedge clk);
    chk("err_sticky", int'(err), 1);
    dp_en = 1'b1;
    @(posedge clk); #1;
    send_vec(2, 1'b1);
    @(negedge clk);
    chk("err_cleared", int'(err), 0);
    wait_idle();

    // Reset during EMIT of row 2 abandons the vector.
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    send_vec(0, 1'b1);
    for (int r = 0; r < 2; r++) begin
      wait_valid();
      pulse_ready();
    end
    wait_valid();
    chk("pre_rst_idx", int'(bus.out_idx), 2);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_dp_rst", int'(bus.dp_rst), 1);
    chk("mid_rst_out_idx", int'(bus.out_idx), 0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    send_vec(1, 1'b1);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
